ahb_lite_interconnect: RTL
==========================

AHB_LITE_INTERCONNECT -- requirements
Module: ahb_lite_interconnect

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave ports (legal 1..8).
REQ-002 SHALL have parameter SLV_BASE, default {0x4001_0000,0x4000_0000,0x2000_0000,0x0000_0000}, packed 32-bit base per slave (slave 0 in LSBs).
REQ-003 SHALL have parameter SLV_MASK, default {0xFFFF_0000,0xFFFF_0000,0xE000_0000,0xE000_0000}, packed 32-bit compare mask per slave.
REQ-004 SHALL have port HCLK  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have master-side inputs HADDR 32, HTRANS 2, HWRITE 1, HSIZE 3, HBURST 3, HPROT 4, HWDATA 32.
REQ-007 SHALL have master-side outputs HRDATA 32, HREADY 1, HRESP 1 (muxed data-phase response).
REQ-008 SHALL have port HSEL  output  NUM_SLAVES  one-hot address-phase slave select.
REQ-009 SHALL have port HREADYMUX  output  1  copy of HREADY, broadcast to all slaves.
REQ-010 SHALL have slave inputs HRDATA_S 32*NUM_SLAVES, HREADYOUT_S NUM_SLAVES, HRESP_S NUM_SLAVES.
REQ-011 SHALL have port ERR_COUNT  output  16  saturating count of default-slave ERROR responses.
REQ-012 SHALL broadcast HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HWDATA unchanged to all slaves.

Function
REQ-013 SHALL decode slave i when (HADDR & MASK_i) == BASE_i; combinational, address phase.
REQ-014 SHALL select lowest matching index on overlap; HSEL never has more than one bit set.
REQ-015 SHALL route no-match addresses to an internal default slave; HSEL all zero then.
REQ-016 SHALL register the decoded target (slave index or default) as data-phase select only when HREADY=1.
REQ-017 SHALL hold the data-phase select unchanged while HREADY=0.
REQ-018 SHALL drive HRDATA/HREADY/HRESP from the data-phase-selected slave's HRDATA_S/HREADYOUT_S/HRESP_S, zero added latency.
REQ-019 SHALL, with default slave selected, drive HRDATA=0.
REQ-020 Default slave SHALL answer IDLE/BUSY with OKAY, zero wait: HREADY=1, HRESP=0.
REQ-021 Default slave SHALL answer NONSEQ/SEQ with two-cycle ERROR: FSM OKAY -> ERR1 (HREADY=0,HRESP=1) -> ERR2 (HREADY=1,HRESP=1) -> OKAY.
REQ-022 Default slave SHALL enter ERR1 in the cycle after an unmapped NONSEQ/SEQ is accepted (HREADY=1).
REQ-023 SHALL accept a new address phase during ERR2; back-to-back unmapped transfers SHALL go ERR2 -> ERR1.
REQ-024 SHALL increment ERR_COUNT by 1 on each ERR1 entry; saturate at 0xFFFF, no wrap.
REQ-025 SHALL pass slave HRESP/HREADYOUT through unmodified (slave-generated ERROR not counted).
REQ-026 SHALL not decode/latch while HREADY=0; master address is held per protocol.
REQ-027 With NUM_SLAVES=1, SHALL still provide default slave for unmapped addresses.

Reset
REQ-028 SHALL on HRESETn=0, immediately: data-phase select=default, FSM=OKAY, ERR_COUNT=0.
REQ-029 SHALL during reset drive HREADY=1, HRESP=0, HRDATA=0, HREADYMUX=1; HSEL follows HADDR decode.
REQ-030 SHALL abandon any in-flight ERROR sequence on reset mid-operation; first post-reset cycle is OKAY.

Verification
REQ-031 Read NONSEQ 0x2000_0010, slave 1 HRDATA_S=0xCAFE_0001, HREADYOUT=1 -> HSEL=4'b0010, next cycle HRDATA=0xCAFE_0001, HRESP=0.
REQ-032 Write NONSEQ 0x4001_0004, slave 3 HREADYOUT low 2 cycles -> HSEL=4'b1000, HREADY low 2 data cycles, following address held, not redecoded.
REQ-033 NONSEQ 0x8000_0000 -> HSEL=0, then HREADY=0/HRESP=1, then HREADY=1/HRESP=1, ERR_COUNT=1.
REQ-034 Two back-to-back NONSEQ 0x9000_0000 -> ERR1,ERR2,ERR1,ERR2, ERR_COUNT=2; IDLE 0x9000_0000 -> OKAY, no increment.
REQ-035 Force ERR_COUNT to 0xFFFF via 65535 errors, one more unmapped NONSEQ -> ERR_COUNT stays 0xFFFF.
REQ-036 Assert HRESETn=0 during ERR1 -> HREADY=1, HRESP=0, ERR_COUNT=0 same cycle; post-reset read 0x0000_0000 hits slave 0.

Source files
------------

// File: rtl/ahb_lite_interconnect.sv
// AHB-Lite single-master interconnect: address decoder, data-phase response mux
// and an internal default slave that answers unmapped transfers with a two-cycle ERROR.
module ahb_lite_interconnect #(
  parameter int                         NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0]   SLV_BASE   = {32'h4001_0000, 32'h4000_0000,
                                                      32'h2000_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0]   SLV_MASK   = {32'hFFFF_0000, 32'hFFFF_0000,
                                                      32'hE000_0000, 32'hE000_0000}
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [31:0]                  HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [3:0]                   HPROT,
  input  logic [31:0]                  HWDATA,
  output logic [31:0]                  HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [NUM_SLAVES-1:0]        HSEL,
  output logic                         HREADYMUX,
  output logic [31:0]                  HADDR_S,
  output logic [1:0]                   HTRANS_S,
  output logic                         HWRITE_S,
  output logic [2:0]                   HSIZE_S,
  output logic [2:0]                   HBURST_S,
  output logic [3:0]                   HPROT_S,
  output logic [31:0]                  HWDATA_S,
  input  logic [32*NUM_SLAVES-1:0]     HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic [15:0]                  ERR_COUNT
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {DS_OKAY, DS_ERR1, DS_ERR2} ds_state_t;

  logic                  hit;
  logic [IDX_W-1:0]      idx;
  logic                  dsel_def_p1;
  logic [IDX_W-1:0]      dsel_idx_p1;
  ds_state_t             ds_state, ds_next;
  logic                  def_ready, def_resp;
  logic [15:0]           err_cnt;

  assign HADDR_S   = HADDR;
  assign HTRANS_S  = HTRANS;
  assign HWRITE_S  = HWRITE;
  assign HSIZE_S   = HSIZE;
  assign HBURST_S  = HBURST;
  assign HPROT_S   = HPROT;
  assign HWDATA_S  = HWDATA;
  assign HREADYMUX = HREADY;
  assign ERR_COUNT = err_cnt;

  // Address phase: scanning downward lets the lowest matching index win
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    HSEL = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        idx     = IDX_W'(i);
        HSEL    = '0;
        HSEL[i] = 1'b1;
      end
    end
  end

  // Data phase: target captured only when the bus accepts the address
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_def_p1 <= 1'b1;
      dsel_idx_p1 <= '0;
    end else if (HREADY) begin
      dsel_def_p1 <= !hit;
      dsel_idx_p1 <= idx;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ds_state <= DS_OKAY;
    else          ds_state <= ds_next;
  end

  // An accepted unmapped NONSEQ/SEQ (re)starts the ERROR pair, including from ERR2
  always_comb begin
    ds_next = DS_OKAY;
    if (HREADY && !hit && HTRANS[1]) ds_next = DS_ERR1;
    else if (ds_state == DS_ERR1)    ds_next = DS_ERR2;
  end

  always_comb begin
    def_ready = (ds_state != DS_ERR1);
    def_resp  = (ds_state != DS_OKAY);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      err_cnt <= '0;
    else if (ds_next == DS_ERR1 && err_cnt != 16'hFFFF)
      err_cnt <= err_cnt + 16'd1;
  end

  always_comb begin
    if (dsel_def_p1) begin
      HRDATA = '0;
      HREADY = def_ready;
      HRESP  = def_resp;
    end else begin
      HRDATA = HRDATA_S[32*dsel_idx_p1 +: 32];
      HREADY = HREADYOUT_S[dsel_idx_p1];
      HRESP  = HRESP_S[dsel_idx_p1];
    end
  end

endmodule
